n64_cmd_rx: RTL and testbench

N64_CMD_RX -- requirements
Module: n64_cmd_rx

---
 rtl/n64_pkg.sv | 40 ++++
 rtl/n64_crc8.sv | 33 +++
 rtl/n64_cmd_rx.sv | 240 ++++++++++++++++++++++++
 tb/tb_n64_cmd_rx.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_pkg.sv
`default_nettype none
// ============================================================================
// Module      : n64_pkg
// Description : Shared constants, FSM state type and CRC step for the N64
//               command receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package n64_pkg;

    localparam logic [7:0] CMD_INFO   = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BADCMD  = 3'd1;
    localparam logic [2:0] ERR_SHORT   = 3'd2;
    localparam logic [2:0] ERR_OVERRUN = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    localparam logic [7:0] CRC_POLY = 8'h85;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_STOP = 3'd4
    } n64_state_e;

    // One MSB-first shift of the CRC register with one input bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic din);
        logic fb;
        fb = crc_in[7] ^ din;
        return {crc_in[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/n64_crc8.sv
`default_nettype none
// ============================================================================
// Module      : n64_crc8
// Description : Bit-serial CRC-8 (poly 0x85, init 0x00, no final XOR).
// Revision    : 1.0 - initial release
// ============================================================================
module n64_crc8
    import n64_pkg::*;
(
    input  logic       sample_clk,
    input  logic       reset_n,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic       i_bit,
    output logic [7:0] o_remainder
);

    logic [7:0] r_crc;

    always_ff @(posedge sample_clk) begin
        if (!reset_n) begin
            r_crc <= 8'h00;
        end else if (i_clear) begin
            r_crc <= 8'h00;
        end else if (i_enable) begin
            r_crc <= crc8_step(r_crc, i_bit);
        end
    end

    assign o_remainder = r_crc;

endmodule
`default_nettype wire

// File: rtl/n64_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module      : n64_cmd_rx
// Description : Receives N64 command frames (command, address, write payload)
//               from a recovered bit stream and reports completion or errors.
// Revision    : 1.0 - initial release
// ============================================================================
module n64_cmd_rx
    import n64_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_BYTES  = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              sample_clk,
    input  logic              reset_n,
    input  logic              cur_operation,
    input  logic              rx_bit_valid,
    input  logic              rx_bit,
    input  logic              rx_stop,
    output logic [7:0]        cmd,
    output logic              cmd_valid,
    output logic [ADDR_W-1:0] address,
    output logic              addr_valid,
    output logic [7:0]        wr_data,
    output logic              wr_valid,
    output logic [7:0]        crc,
    output logic              frame_done,
    output logic              tx_handoff,
    output logic              frame_err,
    output logic [2:0]        err_code
);

    localparam int c_data_bits  = 8 * DATA_BYTES;
    localparam int c_cnt_w_data = $clog2(c_data_bits + 1);
    localparam int c_cnt_w_addr = $clog2(ADDR_W + 1);
    // Wide enough for both the payload and the longest address field.
    localparam int c_cnt_w      = (c_cnt_w_data > c_cnt_w_addr) ? c_cnt_w_data : c_cnt_w_addr;
    localparam int c_tmo_w      = $clog2(TIMEOUT_CYC + 1);

    n64_state_e          r_state, w_state_nxt;
    logic [c_cnt_w-1:0]  r_bit_cnt, w_bit_cnt_nxt, w_bit_cnt_inc;
    logic [c_tmo_w-1:0]  r_tmo_cnt;
    logic [ADDR_W-1:0]   r_shift, w_shift_in;
    logic                w_timeout;

    logic                w_cmd_valid, w_addr_valid, w_wr_valid, w_frame_done, w_frame_err;
    logic [2:0]          w_err_code;
    logic                w_crc_clr, w_crc_en;

    logic [7:0]          r_cmd, r_wr_data;
    logic [ADDR_W-1:0]   r_address;
    logic                r_cmd_valid, r_addr_valid, r_wr_valid;
    logic                r_frame_done, r_tx_handoff, r_frame_err;
    logic [2:0]          r_err_code;

    assign w_bit_cnt_inc = r_bit_cnt + 1'b1;
    assign w_shift_in    = {r_shift[ADDR_W-2:0], rx_bit};
    assign w_timeout     = (r_tmo_cnt == c_tmo_w'(TIMEOUT_CYC - 1));

    always_ff @(posedge sample_clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_cmd_valid   = 1'b0;
        w_addr_valid  = 1'b0;
        w_wr_valid    = 1'b0;
        w_frame_done  = 1'b0;
        w_frame_err   = 1'b0;
        w_err_code    = ERR_NONE;
        w_crc_clr     = 1'b0;
        w_crc_en      = 1'b0;

        // The bit strobe is handled first; a coincident stop is applied afterwards.
        case (r_state)
            ST_IDLE: begin
                if (rx_bit_valid) begin
                    w_state_nxt   = ST_CMD;
                    w_bit_cnt_nxt = c_cnt_w'(1);
                end
            end
            ST_CMD: begin
                if (rx_bit_valid) begin
                    w_bit_cnt_nxt = w_bit_cnt_inc;
                    if (w_bit_cnt_inc == c_cnt_w'(8)) begin
                        w_cmd_valid   = 1'b1;
                        w_bit_cnt_nxt = '0;
                        case (w_shift_in[7:0])
                            CMD_INFO, CMD_STATUS, CMD_RESET: w_state_nxt = ST_STOP;
                            CMD_READ, CMD_WRITE:             w_state_nxt = ST_ADDR;
                            default: begin
                                w_state_nxt = ST_IDLE;
                                w_frame_err = 1'b1;
                                w_err_code  = ERR_BADCMD;
                            end
                        endcase
                    end
                end
            end
            ST_ADDR: begin
                if (rx_bit_valid) begin
                    w_bit_cnt_nxt = w_bit_cnt_inc;
                    if (w_bit_cnt_inc == c_cnt_w'(ADDR_W)) begin
                        w_addr_valid  = 1'b1;
                        w_bit_cnt_nxt = '0;
                        if (r_cmd == CMD_WRITE) begin
                            w_state_nxt = ST_DATA;
                            w_crc_clr   = 1'b1;
                        end else begin
                            w_state_nxt = ST_STOP;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (rx_bit_valid) begin
                    w_crc_en      = 1'b1;
                    w_bit_cnt_nxt = w_bit_cnt_inc;
                    if (w_bit_cnt_inc[2:0] == 3'd0) begin
                        w_wr_valid = 1'b1;
                    end
                    if (w_bit_cnt_inc == c_cnt_w'(c_data_bits)) begin
                        w_state_nxt   = ST_STOP;
                        w_bit_cnt_nxt = '0;
                    end
                end
            end
            ST_STOP: begin
                if (rx_bit_valid) begin
                    w_state_nxt = ST_IDLE;
                    w_frame_err = 1'b1;
                    w_err_code  = ERR_OVERRUN;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_bit_cnt_nxt = '0;
            end
        endcase

        if (rx_stop && (w_state_nxt != ST_IDLE)) begin
            if (w_state_nxt == ST_STOP) begin
                w_frame_done = 1'b1;
            end else begin
                w_frame_err = 1'b1;
                w_err_code  = ERR_SHORT;
            end
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
        end else if ((r_state != ST_IDLE) && !rx_bit_valid && !rx_stop && w_timeout) begin
            w_frame_err   = 1'b1;
            w_err_code    = ERR_TIMEOUT;
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
        end

        // An outgoing transmission silently abandons any frame in progress.
        if (cur_operation) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
            w_cmd_valid   = 1'b0;
            w_addr_valid  = 1'b0;
            w_wr_valid    = 1'b0;
            w_frame_done  = 1'b0;
            w_frame_err   = 1'b0;
            w_err_code    = ERR_NONE;
            w_crc_clr     = 1'b0;
            w_crc_en      = 1'b0;
        end
    end

    always_ff @(posedge sample_clk) begin
        if (!reset_n) begin
            r_bit_cnt    <= '0;
            r_tmo_cnt    <= '0;
            r_shift      <= '0;
            r_cmd        <= 8'h00;
            r_address    <= '0;
            r_wr_data    <= 8'h00;
            r_cmd_valid  <= 1'b0;
            r_addr_valid <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            r_tx_handoff <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_tmo_cnt    <= ((w_state_nxt == ST_IDLE) || rx_bit_valid) ? '0 : r_tmo_cnt + 1'b1;
            r_cmd_valid  <= w_cmd_valid;
            r_addr_valid <= w_addr_valid;
            r_wr_valid   <= w_wr_valid;
            r_frame_done <= w_frame_done;
            r_tx_handoff <= w_frame_done;
            r_frame_err  <= w_frame_err;
            r_err_code   <= w_err_code;
            if (rx_bit_valid && !cur_operation) begin
                r_shift <= w_shift_in;
            end
            if (w_cmd_valid) begin
                r_cmd <= w_shift_in[7:0];
            end
            if (w_addr_valid) begin
                r_address <= w_shift_in;
            end
            if (w_wr_valid) begin
                r_wr_data <= w_shift_in[7:0];
            end
        end
    end

    n64_crc8 u_crc (
        .sample_clk  (sample_clk),
        .reset_n     (reset_n),
        .i_clear     (w_crc_clr),
        .i_enable    (w_crc_en),
        .i_bit       (rx_bit),
        .o_remainder (crc)
    );

    assign cmd        = r_cmd;
    assign cmd_valid  = r_cmd_valid;
    assign address    = r_address;
    assign addr_valid = r_addr_valid;
    assign wr_data    = r_wr_data;
    assign wr_valid   = r_wr_valid;
    assign frame_done = r_frame_done;
    assign tx_handoff = r_tx_handoff;
    assign frame_err  = r_frame_err;
    assign err_code   = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_n64_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_n64_cmd_rx
// Description : Frame-level model and directed frames for n64_cmd_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_n64_cmd_rx;

    localparam int ADDR_W      = 16;
    localparam int DATA_BYTES  = 32;
    localparam int TIMEOUT_CYC = 1024;

    logic              sample_clk    = 1'b0;
    logic              reset_n       = 1'b0;
    logic              cur_operation = 1'b0;
    logic              rx_bit_valid  = 1'b0;
    logic              rx_bit        = 1'b0;
    logic              rx_stop       = 1'b0;
    logic [7:0]        cmd;
    logic              cmd_valid;
    logic [ADDR_W-1:0] address;
    logic              addr_valid;
    logic [7:0]        wr_data;
    logic              wr_valid;
    logic [7:0]        crc;
    logic              frame_done;
    logic              tx_handoff;
    logic              frame_err;
    logic [2:0]        err_code;

    n64_cmd_rx #(
        .ADDR_W      (ADDR_W),
        .DATA_BYTES  (DATA_BYTES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .sample_clk    (sample_clk),
        .reset_n       (reset_n),
        .cur_operation (cur_operation),
        .rx_bit_valid  (rx_bit_valid),
        .rx_bit        (rx_bit),
        .rx_stop       (rx_stop),
        .cmd           (cmd),
        .cmd_valid     (cmd_valid),
        .address       (address),
        .addr_valid    (addr_valid),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .crc           (crc),
        .frame_done    (frame_done),
        .tx_handoff    (tx_handoff),
        .frame_err     (frame_err),
        .err_code      (err_code)
    );

    always #5 sample_clk = ~sample_clk;

    // Frame-level model: position within the frame decides each output.
    logic              m_live = 1'b0;
    logic              m_open = 1'b0;
    int                m_n    = 0;
    int                m_tmo  = 0;
    logic [7:0]        m_cmd_sh = 8'h00;
    logic [ADDR_W-1:0] m_addr_sh = '0;
    logic [7:0]        m_byte = 8'h00;
    logic [7:0]        e_cmd = 8'h00, e_wr = 8'h00, e_crc = 8'h00;
    logic [ADDR_W-1:0] e_addr = '0;
    logic              e_cmd_valid = 1'b0, e_addr_valid = 1'b0, e_wr_valid = 1'b0;
    logic              e_done = 1'b0, e_err = 1'b0;
    logic [2:0]        e_code = 3'd0;

    function automatic int frame_len(input logic [7:0] c);
        case (c)
            8'h00, 8'h01, 8'hFF: return 8;
            8'h02:               return 8 + ADDR_W;
            8'h03:               return 8 + ADDR_W + 8 * DATA_BYTES;
            default:             return 0;
        endcase
    endfunction

    function automatic logic [7:0] crc_bit(input logic [7:0] c, input logic b);
        return (c[7] ^ b) ? ({c[6:0], 1'b0} ^ 8'h85) : {c[6:0], 1'b0};
    endfunction

    always @(posedge sample_clk) begin
        e_cmd_valid  = 1'b0;
        e_addr_valid = 1'b0;
        e_wr_valid   = 1'b0;
        e_done       = 1'b0;
        e_err        = 1'b0;
        e_code       = 3'd0;
        if (!reset_n) begin
            m_live = 1'b1;
            m_open = 1'b0;
            m_n    = 0;
            m_tmo  = 0;
            e_cmd  = 8'h00;
            e_addr = '0;
            e_wr   = 8'h00;
            e_crc  = 8'h00;
        end else if (cur_operation) begin
            m_open = 1'b0;
        end else begin
            if (rx_bit_valid) begin
                if (!m_open) begin
                    m_open = 1'b1;
                    m_n    = 0;
                end
                m_tmo = 0;
                m_n   = m_n + 1;
                if (m_n > 8 && m_n > frame_len(m_cmd_sh)) begin
                    e_err = 1'b1; e_code = 3'd3; m_open = 1'b0;
                end else if (m_n <= 8) begin
                    m_cmd_sh = {m_cmd_sh[6:0], rx_bit};
                    if (m_n == 8) begin
                        e_cmd = m_cmd_sh;
                        e_cmd_valid = 1'b1;
                        if (frame_len(m_cmd_sh) == 0) begin
                            e_err = 1'b1; e_code = 3'd1; m_open = 1'b0;
                        end
                    end
                end else if (m_n <= 8 + ADDR_W) begin
                    m_addr_sh = {m_addr_sh[ADDR_W-2:0], rx_bit};
                    if (m_n == 8 + ADDR_W) begin
                        e_addr = m_addr_sh;
                        e_addr_valid = 1'b1;
                        if (m_cmd_sh == 8'h03) e_crc = 8'h00;
                    end
                end else begin
                    m_byte = {m_byte[6:0], rx_bit};
                    e_crc  = crc_bit(e_crc, rx_bit);
                    if ((m_n - 8 - ADDR_W) % 8 == 0) begin
                        e_wr = m_byte;
                        e_wr_valid = 1'b1;
                    end
                end
            end
            if (rx_stop && m_open) begin
                if (m_n == frame_len(m_cmd_sh)) e_done = 1'b1;
                else begin e_err = 1'b1; e_code = 3'd2; end
                m_open = 1'b0;
            end else if (m_open && !rx_bit_valid) begin
                m_tmo = m_tmo + 1;
                if (m_tmo == TIMEOUT_CYC) begin
                    e_err = 1'b1; e_code = 3'd4; m_open = 1'b0;
                end
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cnt_done = 0, cnt_ho = 0, cnt_err = 0, cnt_wr = 0;
    logic [2:0] last_code = 3'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    task automatic compare_all();
        if (m_live) begin
            chk("cmd",        32'(cmd),        32'(e_cmd));
            chk("cmd_valid",  32'(cmd_valid),  32'(e_cmd_valid));
            chk("address",    32'(address),    32'(e_addr));
            chk("addr_valid", 32'(addr_valid), 32'(e_addr_valid));
            chk("wr_data",    32'(wr_data),    32'(e_wr));
            chk("wr_valid",   32'(wr_valid),   32'(e_wr_valid));
            chk("crc",        32'(crc),        32'(e_crc));
            chk("frame_done", 32'(frame_done), 32'(e_done));
            chk("tx_handoff", 32'(tx_handoff), 32'(e_done));
            chk("frame_err",  32'(frame_err),  32'(e_err));
            chk("err_code",   32'(err_code),   32'(e_code));
        end
        if (frame_done === 1'b1) cnt_done++;
        if (tx_handoff === 1'b1) cnt_ho++;
        if (wr_valid === 1'b1) cnt_wr++;
        if (frame_err === 1'b1) begin
            cnt_err++;
            last_code = err_code;
        end
    endtask

    task automatic tick();
        @(negedge sample_clk);
        compare_all();
        @(posedge sample_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            rx_bit_valid = 1'b1;
            rx_bit       = v[i];
            tick();
        end
        rx_bit_valid = 1'b0;
        rx_bit       = 1'b0;
    endtask

    task automatic send_stop();
        rx_stop = 1'b1;
        tick();
        rx_stop = 1'b0;
    endtask

    int s_done, s_ho, s_err, s_wr, waited;

    task automatic snap();
        s_done = cnt_done;
        s_ho   = cnt_ho;
        s_err  = cnt_err;
        s_wr   = cnt_wr;
    endtask

    initial begin
        idle(3);
        chk("reset_cmd",      32'(cmd),      32'h00);
        chk("reset_address",  32'(address),  32'h0);
        chk("reset_crc",      32'(crc),      32'h00);
        chk("reset_err_code", 32'(err_code), 32'h0);
        reset_n = 1'b1;
        idle(2);

        // Stop with no frame open is ignored.
        snap();
        send_stop();
        idle(3);
        chk("idle_stop_ignored", 32'((cnt_done - s_done) + (cnt_err - s_err)), 32'd0);

        // STATUS frame.
        snap();
        send_bits(32'h01, 8);
        send_stop();
        idle(3);
        chk("status_cmd",     32'(cmd),                 32'h01);
        chk("status_done",    32'(cnt_done - s_done),   32'd1);
        chk("status_handoff", 32'(cnt_ho - s_ho),       32'd1);
        chk("status_no_err",  32'(cnt_err - s_err),     32'd0);

        // READ frame.
        snap();
        send_bits(32'h02, 8);
        send_bits(32'h8001, ADDR_W);
        send_stop();
        idle(3);
        chk("read_address", 32'(address),             32'h8001);
        chk("read_done",    32'(cnt_done - s_done),   32'd1);

        // WRITE frame with payload 0x00..0x1F.
        snap();
        send_bits(32'h03, 8);
        send_bits(32'hC000, ADDR_W);
        for (int b = 0; b < DATA_BYTES; b++) begin
            send_bits(32'(b), 8);
            if (b == 1) chk("crc_after_2_bytes", 32'(crc), 32'h85);
            if (b == 2) chk("crc_after_3_bytes", 32'(crc), 32'h18);
        end
        send_stop();
        idle(3);
        chk("write_wr_count", 32'(cnt_wr - s_wr),     32'(DATA_BYTES));
        chk("write_last_byte", 32'(wr_data),          32'h1F);
        chk("write_done",     32'(cnt_done - s_done), 32'd1);

        // Error frames.
        snap();
        send_bits(32'h55, 8);
        idle(3);
        chk("badcmd_err",  32'(cnt_err - s_err), 32'd1);
        chk("badcmd_code", 32'(last_code),       32'd1);

        snap();
        send_bits(32'h02, 8);
        send_bits(32'h155, 10);
        send_stop();
        idle(3);
        chk("short_err",  32'(cnt_err - s_err), 32'd1);
        chk("short_code", 32'(last_code),       32'd2);

        snap();
        send_bits(32'h00, 8);
        send_bits(32'h1, 1);
        idle(3);
        chk("overrun_err",  32'(cnt_err - s_err),     32'd1);
        chk("overrun_code", 32'(last_code),           32'd3);
        chk("overrun_done", 32'(cnt_done - s_done),   32'd0);

        // Stall mid-DATA until the timeout fires.
        snap();
        send_bits(32'h03, 8);
        send_bits(32'hC000, ADDR_W);
        send_bits(32'h00, 8);
        send_bits(32'h01, 8);
        waited = 0;
        while (cnt_err == s_err && waited < TIMEOUT_CYC + 50) begin
            tick();
            waited++;
        end
        chk("timeout_cycles", 32'(waited),    32'(TIMEOUT_CYC + 1));
        chk("timeout_code",   32'(last_code), 32'd4);
        snap();
        send_bits(32'h00, 8);
        send_stop();
        idle(3);
        chk("after_timeout_done", 32'(cnt_done - s_done), 32'd1);

        // TX interrupts a WRITE: frame dropped silently, crc held.
        snap();
        send_bits(32'h03, 8);
        send_bits(32'hC000, ADDR_W);
        send_bits(32'h00, 8);
        send_bits(32'h01, 8);
        send_bits(32'h02, 8);
        cur_operation = 1'b1;
        idle(2);
        send_bits(32'hA5, 8);
        send_stop();
        cur_operation = 1'b0;
        idle(2);
        send_stop();
        idle(3);
        chk("txint_crc_held", 32'(crc),                32'h18);
        chk("txint_no_err",   32'(cnt_err - s_err),    32'd0);
        chk("txint_no_done",  32'(cnt_done - s_done),  32'd0);

        // Final bit and stop in the same cycle complete the frame.
        snap();
        send_bits(32'h00, 7);
        rx_bit_valid = 1'b1;
        rx_bit       = 1'b1;
        rx_stop      = 1'b1;
        tick();
        rx_bit_valid = 1'b0;
        rx_bit       = 1'b0;
        rx_stop      = 1'b0;
        idle(3);
        chk("same_cycle_done", 32'(cnt_done - s_done), 32'd1);
        chk("same_cycle_cmd",  32'(cmd),               32'h01);

        // Reset mid-frame.
        snap();
        send_bits(32'h02, 8);
        send_bits(32'h15, 5);
        reset_n = 1'b0;
        idle(2);
        chk("rst_cmd",     32'(cmd),             32'h00);
        chk("rst_address", 32'(address),         32'h0);
        chk("rst_crc",     32'(crc),             32'h00);
        chk("rst_wr_data", 32'(wr_data),         32'h00);
        chk("rst_no_err",  32'(cnt_err - s_err), 32'd0);
        reset_n = 1'b1;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
